// File: rtl/sha3_padder.sv
// sha3_padder: packs a 64-bit message word stream into Keccak rate blocks.
// It applies SHA-3 pad10*1 with a domain suffix byte and presents full 25-lane
// state blocks to the downstream round/XOR engine. Capacity lanes are always zero.
//
// Ports:
//   clk, nrst        clock (rising edge), asynchronous active-low reset
//   in_data          message word, byte k at bits [8k+7:8k]
//   in_bytes         valid bytes in word (0..8; <8 only with in_last)
//   in_last          final word of message
//   in_valid/ready   input handshake
//   blk_data         state block, rate lane i at [i%5][i/5]
//   blk_valid/ready  output handshake
//   blk_last         block is the final (padded) block of the message
//
// Optional build macro SHA3_PADDER_SUFFIX_PORT_EN: replaces parameter SUFFIX
// with input port in_suffix, sampled with the in_last word.
module sha3_padder #(
   parameter int unsigned RATE_LANES = 17
`ifndef SHA3_PADDER_SUFFIX_PORT_EN
   , parameter logic [7:0] SUFFIX = 8'h06
`endif
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [63:0]            in_data,
   input  logic [3:0]             in_bytes,
   input  logic                   in_last,
   input  logic                   in_valid,
`ifdef SHA3_PADDER_SUFFIX_PORT_EN
   input  logic [7:0]             in_suffix,
`endif
   output logic                   in_ready,
   output logic [0:4][0:4][63:0]  blk_data,
   output logic                   blk_valid,
   output logic                   blk_last,
   input  logic                   blk_ready
);

   localparam int unsigned CntW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;

   localparam logic [1:0] StFill     = 2'd0;
   localparam logic [1:0] StSend     = 2'd1;
   localparam logic [1:0] StSendXtra = 2'd2;

   logic [1:0]                   state_q, state_d;
   logic [CntW-1:0]              cnt_q, cnt_d;
   logic [RATE_LANES-1:0][63:0]  lane_q, lane_d;
   logic                         xtra_q, xtra_d;
   logic                         last_q, last_d;
   logic [7:0]                   sfx_q, sfx_d;
   logic                         rdy_q, rdy_d;

   logic [7:0]  sfx_in;
   logic [63:0] masked;
   logic [63:0] word_sfx;
   logic        accept;
   logic        cnt_end;

`ifdef SHA3_PADDER_SUFFIX_PORT_EN
   assign sfx_in = in_suffix;
`else
   assign sfx_in = SUFFIX;
`endif

   assign accept  = in_valid & rdy_q;
   assign cnt_end = (cnt_q == CntW'(RATE_LANES - 1));

   // Zero the bytes past in_bytes, and a copy with the suffix placed right
   // after the last message byte.
   always_comb begin
      masked   = '0;
      word_sfx = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         if (in_bytes > 4'(k)) masked[8*k +: 8] = in_data[8*k +: 8];
      end
      word_sfx = masked;
      for (int unsigned k = 0; k < 8; k++) begin
         if (in_bytes == 4'(k)) word_sfx[8*k +: 8] = masked[8*k +: 8] | sfx_in;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lane_d  = lane_q;
      xtra_d  = xtra_q;
      last_d  = last_q;
      sfx_d   = sfx_q;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               // Write the current lane; padding is ORed in afterwards so it
               // may land in the lane just written.
               for (int unsigned i = 0; i < RATE_LANES; i++) begin
                  if (cnt_q == CntW'(i)) begin
                     lane_d[i] = (in_last && in_bytes != 4'd8) ? word_sfx : masked;
                  end
               end
               if (!in_last) begin
                  if (cnt_end) begin
                     state_d = StSend;
                     last_d  = 1'b0;
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end else begin
                  sfx_d   = sfx_in;
                  state_d = StSend;
                  if (in_bytes != 4'd8) begin
                     lane_d[RATE_LANES-1][63:56] = lane_d[RATE_LANES-1][63:56] | 8'h80;
                     last_d = 1'b1;
                  end else if (!cnt_end) begin
                     for (int unsigned i = 0; i < RATE_LANES; i++) begin
                        if (cnt_q + CntW'(1) == CntW'(i)) lane_d[i][7:0] = lane_d[i][7:0] | sfx_in;
                     end
                     lane_d[RATE_LANES-1][63:56] = lane_d[RATE_LANES-1][63:56] | 8'h80;
                     last_d = 1'b1;
                  end else begin
                     // Full block, no room for padding: follow with a pad-only block.
                     last_d = 1'b0;
                     xtra_d = 1'b1;
                  end
               end
            end
         end
         StSend, StSendXtra: begin
            if (blk_ready) begin
               lane_d = '0;
               cnt_d  = '0;
               if (state_q == StSend && xtra_q) begin
                  lane_d[0][7:0] = sfx_q;
                  lane_d[RATE_LANES-1][63:56] = lane_d[RATE_LANES-1][63:56] | 8'h80;
                  xtra_d  = 1'b0;
                  last_d  = 1'b1;
                  state_d = StSendXtra;
               end else begin
                  last_d  = 1'b0;
                  state_d = StFill;
               end
            end
         end
         default: state_d = StFill;
      endcase
      rdy_d = (state_d == StFill);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= StFill;
         cnt_q   <= '0;
         lane_q  <= '0;
         xtra_q  <= 1'b0;
         last_q  <= 1'b0;
         sfx_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         xtra_q  <= xtra_d;
         last_q  <= last_d;
         sfx_q   <= sfx_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign blk_valid = (state_q != StFill);
   assign blk_last  = last_q;

   always_comb begin
      blk_data = '0;
      for (int i = 0; i < int'(RATE_LANES); i++) begin
         blk_data[i % 5][i / 5] = lane_q[i];
      end
   end

   // Illegal byte counts are not supported.
   always_ff @(posedge clk) begin
      if (nrst && in_valid && in_ready) begin
         assert (in_bytes <= 4'd8);
         assert (in_last || in_bytes == 4'd8);
      end
   end

endmodule

// File: tb/tb_sha3_padder.sv
module tb_sha3_padder;

   logic                  clk = 1'b0;
   logic                  nrst = 1'b0;
   logic [63:0]           in_data = '0;
   logic [3:0]            in_bytes = '0;
   logic                  in_last = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [0:4][0:4][63:0] blk_data;
   logic                  blk_valid;
   logic                  blk_last;
   logic                  blk_ready = 1'b0;
`ifdef SHA3_PADDER_SUFFIX_PORT_EN
   logic [7:0]            in_suffix = 8'h06;
`endif

   always #5 clk = ~clk;

   sha3_padder #(.RATE_LANES(17)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .in_data   (in_data),
      .in_bytes  (in_bytes),
      .in_last   (in_last),
      .in_valid  (in_valid),
`ifdef SHA3_PADDER_SUFFIX_PORT_EN
      .in_suffix (in_suffix),
`endif
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_last  (blk_last),
      .blk_ready (blk_ready)
   );

   int tests = 0;
   int fails = 0;

   typedef logic [63:0] lanes_t [25];

   typedef struct {
      logic [63:0] data;
      logic [3:0]  bytes;
      logic [63:0] l0;
      logic [63:0] l1;
      logic [63:0] l16;
   } vec_t;

   localparam logic [63:0] Pad80 = 64'h8000_0000_0000_0000;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s got %h required %h", nm, got, req);
      end
   endtask

   task automatic put_word(input logic [63:0] d, input logic [3:0] b, input logic l);
      int n = 0;
      in_data  = d;
      in_bytes = b;
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL put_word_timeout in_ready %0b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_block(input string nm, input int hold,
                            output logic [0:4][0:4][63:0] d, output logic l);
      int n = 0;
      bit stable = 1'b1;
      while (!blk_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!blk_valid) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout blk_valid %0b required 1", nm, blk_valid);
      end
      d = blk_data;
      l = blk_last;
      if (hold > 0) begin
         if (in_ready !== 1'b0) stable = 1'b0;
         for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (blk_data !== d || blk_last !== l || blk_valid !== 1'b1 || in_ready !== 1'b0)
               stable = 1'b0;
         end
         check({nm, "_hold_stable"}, 64'(stable), 64'd1);
      end
      blk_ready = 1'b1;
      @(negedge clk);
      blk_ready = 1'b0;
   endtask

   task automatic check_blk(input string nm, input logic [0:4][0:4][63:0] d, input logic l,
                            input lanes_t e, input logic el);
      int bad = -1;
      for (int i = 0; i < 25; i++) begin
         if (d[i % 5][i / 5] !== e[i] && bad < 0) bad = i;
      end
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s lane %0d got %h required %h", nm, bad, d[bad % 5][bad / 5], e[bad]);
      end
      check({nm, "_last"}, 64'(l), 64'(el));
   endtask

   function automatic lanes_t zero_lanes();
      lanes_t z;
      for (int i = 0; i < 25; i++) z[i] = '0;
      return z;
   endfunction

   function automatic logic [63:0] rep(input int i);
      logic [7:0] b;
      b = 8'(i + 1);
      return {8{b}};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [6];
      lanes_t e;
      logic [0:4][0:4][63:0] d;
      logic l;
      bit quiet;

      vecs[0] = '{64'h0, 4'd0, 64'h06, 64'h0, Pad80};
      vecs[1] = '{64'h0000_0000_0063_6261, 4'd3, 64'h0000_0000_0663_6261, 64'h0, Pad80};
      vecs[2] = '{64'hDEAD_BEEF_CAFE_BAAA, 4'd1, 64'h0000_0000_0000_06AA, 64'h0, Pad80};
      vecs[3] = '{64'h1122_3344_5566_7788, 4'd4, 64'h0000_0006_5566_7788, 64'h0, Pad80};
      vecs[4] = '{64'hFFEE_DDCC_BBAA_9988, 4'd7, 64'h06EE_DDCC_BBAA_9988, 64'h0, Pad80};
      vecs[5] = '{64'h0123_4567_89AB_CDEF, 4'd8, 64'h0123_4567_89AB_CDEF, 64'h06, Pad80};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_blk_valid", 64'(blk_valid), 64'd0);
      check("rst_blk_last", 64'(blk_last), 64'd0);
      check("rst_blk_data_or", 64'(|blk_data), 64'd0);
      nrst = 1'b1;
      @(negedge clk);
      check("rst_release_in_ready", 64'(in_ready), 64'd1);

      // Single-word messages
      foreach (vecs[v]) begin
         put_word(vecs[v].data, vecs[v].bytes, 1'b1);
         check($sformatf("vec%0d_latency", v), 64'(blk_valid), 64'd1);
         get_block($sformatf("vec%0d", v), 0, d, l);
         e = zero_lanes();
         e[0]  = vecs[v].l0;
         e[1]  = vecs[v].l1;
         e[16] = vecs[v].l16;
         check_blk($sformatf("vec%0d", v), d, l, e, 1'b1);
      end

      // 135 bytes: suffix and final bit share byte 7 of lane 16
      for (int i = 0; i < 16; i++) put_word(rep(i), 4'd8, 1'b0);
      put_word({8{8'hA5}}, 4'd7, 1'b1);
      get_block("len135", 0, d, l);
      e = zero_lanes();
      for (int i = 0; i < 16; i++) e[i] = rep(i);
      e[16] = {8'h86, {7{8'hA5}}};
      check_blk("len135", d, l, e, 1'b1);

      // 128 bytes: suffix lands in lane 16 byte 0 next to the final bit
      for (int i = 0; i < 16; i++) put_word(rep(i), 4'd8, i == 15);
      get_block("len128", 0, d, l);
      e = zero_lanes();
      for (int i = 0; i < 16; i++) e[i] = rep(i);
      e[16] = 64'h8000_0000_0000_0006;
      check_blk("len128", d, l, e, 1'b1);

      // 136 bytes with backpressure: data block then pad-only block
`ifdef SHA3_PADDER_SUFFIX_PORT_EN
      in_suffix = 8'h1F;
`endif
      for (int i = 0; i < 17; i++) put_word(rep(i), 4'd8, i == 16);
`ifdef SHA3_PADDER_SUFFIX_PORT_EN
      in_suffix = 8'h06;
`endif
      get_block("len136_b1", 10, d, l);
      e = zero_lanes();
      for (int i = 0; i < 17; i++) e[i] = rep(i);
      check_blk("len136_b1", d, l, e, 1'b0);
      get_block("len136_b2", 10, d, l);
      e = zero_lanes();
`ifdef SHA3_PADDER_SUFFIX_PORT_EN
      e[0] = 64'h1F;
`else
      e[0] = 64'h06;
`endif
      e[16] = Pad80;
      check_blk("len136_b2", d, l, e, 1'b1);
      check("after_hs_in_ready", 64'(in_ready), 64'd1);

      // Reset mid-message discards the partial block
      for (int i = 0; i < 5; i++) put_word(rep(i), 4'd8, 1'b0);
      nrst = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      check("midrst_blk_valid", 64'(blk_valid), 64'd0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("midrst_no_block", 64'(blk_valid), 64'd0);
      put_word(64'h0063_6261, 4'd3, 1'b1);
      get_block("midrst_abc", 0, d, l);
      e = zero_lanes();
      e[0]  = 64'h0663_6261;
      e[16] = Pad80;
      check_blk("midrst_abc", d, l, e, 1'b1);
      quiet = 1'b1;
      repeat (5) begin
         if (blk_valid !== 1'b0) quiet = 1'b0;
         @(negedge clk);
      end
      check("midrst_single_block", 64'(quiet), 64'd1);

`ifdef SHA3_PADDER_SUFFIX_PORT_EN
      in_suffix = 8'h1F;
      put_word(64'h0063_6261, 4'd3, 1'b1);
      in_suffix = 8'h06;
      get_block("shake_abc", 0, d, l);
      e = zero_lanes();
      e[0]  = 64'h1F63_6261;
      e[16] = Pad80;
      check_blk("shake_abc", d, l, e, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
